// File: rtl/seq_generator_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_generator_if
//  Description : Control/stream bundle for seq_generator. The slave modport
//                is the generator side and the master modport is the driver side.
//                mon_y exists only when SEQGEN_MONITOR_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_generator_if #(
    parameter int HOLD_W = 4
);
    logic              start;
    logic [HOLD_W-1:0] hold_len;
    logic              a;
    logic              b;
    logic              busy;
    logic              done;
`ifdef SEQGEN_MONITOR_EN
    logic              mon_y;

    modport master (output start, output hold_len,
                    input  a, input b, input busy, input done, input mon_y);
    modport slave  (input  start, input hold_len,
                    output a, output b, output busy, output done, output mon_y);
`else
    modport master (output start, output hold_len,
                    input  a, input b, input busy, input done);
    modport slave  (input  start, input hold_len,
                    output a, output b, output busy, output done);
`endif
endinterface
`default_nettype wire

// File: rtl/seq_generator.sv
`default_nettype none
// ============================================================================
//  Module      : seq_generator
//  Description : Emits one {a,b} burst per accepted start:
//                XOR_PAT, 11, hold_len x 11, 00. busy covers the whole burst
//                and done marks its last cycle. Optional macro
//                SEQGEN_MONITOR_EN adds a detector model driving mon_y.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_generator #(
    parameter int         HOLD_W  = 4,
    parameter logic [1:0] XOR_PAT = 2'b10
) (
    input  wire logic        clk,
    input  wire logic        reset,
    seq_generator_if.slave   bus
);

    // XOR_PAT must differ in its two bits. Otherwise the first step is not a
    // valid pattern.
    generate
        if (!((XOR_PAT == 2'b10) || (XOR_PAT == 2'b01))) begin : g_bad_xor_pat
            $error("seq_generator: XOR_PAT must be 2'b10 or 2'b01");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STEP1 = 3'd1,
        STEP2 = 3'd2,
        HOLD  = 3'd3,
        TERM  = 3'd4
    } state_t;

    state_t            state_q;
    logic [HOLD_W-1:0] cnt_q;
    logic              a_q;
    logic              b_q;
    logic              busy_q;
    logic              done_q;

    // Burst FSM. Every output is registered, so the output values describe the
    // state being entered. The counter counts HOLD cycles down to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= STEP1;
                        cnt_q      <= bus.hold_len;
                        {a_q, b_q} <= XOR_PAT;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                STEP1: begin
                    state_q    <= STEP2;
                    {a_q, b_q} <= 2'b11;
                end
                STEP2: begin
                    if (cnt_q != '0) begin
                        state_q    <= HOLD;
                        {a_q, b_q} <= 2'b11;
                    end else begin
                        state_q    <= TERM;
                        {a_q, b_q} <= 2'b00;
                        done_q     <= 1'b1;
                    end
                end
                HOLD: begin
                    // The counter is nonzero in HOLD. The last hold cycle is
                    // the one where the counter reads 1.
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == HOLD_W'(1)) begin
                        state_q    <= TERM;
                        {a_q, b_q} <= 2'b00;
                        done_q     <= 1'b1;
                    end
                end
                TERM: begin
                    // Any start seen in this cycle is dropped on purpose.
                    state_q    <= IDLE;
                    {a_q, b_q} <= 2'b00;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    {a_q, b_q} <= 2'b00;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a    = a_q;
    assign bus.b    = b_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

`ifdef SEQGEN_MONITOR_EN
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } mon_state_t;

    mon_state_t mon_q;

    // Detector model fed by the registered stream bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mon_q <= S0;
        end else begin
            case (mon_q)
                S0:      mon_q <= (a_q ^ b_q) ? S1 : S0;
                S1:      mon_q <= (a_q & b_q) ? S2 : S0;
                S2:      mon_q <= (a_q | b_q) ? S3 : S0;
                S3:      mon_q <= (a_q | b_q) ? S3 : S0;
                default: mon_q <= S0;
            endcase
        end
    end

    assign bus.mon_y = (mon_q == S1) || (mon_q == S2);
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_generator
//  Description : Randomized scoreboard bench for seq_generator. The driver
//                predicts each accepted burst as a list of per-cycle
//                expectations. A negedge monitor consumes that list.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_generator;

    localparam int         C_HOLD_W  = 4;
    localparam logic [1:0] C_XOR_PAT = 2'b10;

    typedef struct {
        int         cyc;
        logic [1:0] ab;
        logic       done;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;
    int   rem;
    int   ms;
    bit   mon_en;
    exp_t q[$];

    seq_generator_if #(.HOLD_W(C_HOLD_W)) bus ();

    seq_generator #(
        .HOLD_W  (C_HOLD_W),
        .XOR_PAT (C_XOR_PAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs just after an edge. If the model sees the
    // generator idle, predict the full burst that the next edge starts.
    task automatic drive(input logic s, input logic [C_HOLD_W-1:0] l, input bit rel);
        int L;
        @(posedge clk);
        #1;
        if (rel) reset = 1'b1;
        bus.start    = s;
        bus.hold_len = l;
        L = int'(l);
        if (s && rem == 0 && reset) begin
            for (int i = 0; i < L + 3; i++) begin
                exp_t e;
                e.cyc  = cyc + 1 + i;
                e.ab   = (i == 0) ? C_XOR_PAT : ((i == L + 2) ? 2'b00 : 2'b11);
                e.done = (i == L + 2);
                q.push_back(e);
            end
            rem = L + 3;
        end else if (rem > 0) begin
            rem = rem - 1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset     = 1'b0;
        bus.start = 1'b0;
        #1;
        checks++;
        if ({bus.a, bus.b, bus.busy, bus.done} != 4'b0000) begin
            failures++;
            $display("FAIL async_reset: actual a,b,busy,done=%b%b%b%b required 0000",
                     bus.a, bus.b, bus.busy, bus.done);
        end
        q.delete();
        rem = 0;
        ms  = 0;
    endtask

`ifdef SEQGEN_MONITOR_EN
    function automatic int mon_next(input int s, input logic a, input logic b);
        case (s)
            0:       return (a ^ b) ? 1 : 0;
            1:       return (a & b) ? 2 : 0;
            2:       return (a | b) ? 3 : 0;
            default: return (a | b) ? 3 : 0;
        endcase
    endfunction
`endif

    // Scoreboard monitor. It samples mid-cycle. When busy is high it must match
    // the next predicted cycle. When busy is low the stream must be quiet and
    // no prediction may be overdue.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (bus.busy) begin
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL burst_extra cyc=%0d: actual busy=1 ab=%b%b done=%b required idle",
                             cyc, bus.a, bus.b, bus.done);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.cyc != cyc || {bus.a, bus.b} != e.ab || bus.done != e.done) begin
                        failures++;
                        $display("FAIL burst_cycle cyc=%0d: actual ab=%b%b done=%b required cyc=%0d ab=%b done=%b",
                                 cyc, bus.a, bus.b, bus.done, e.cyc, e.ab, e.done);
                    end
                end
            end else begin
                if ({bus.a, bus.b, bus.done} != 3'b000 || (q.size() > 0 && q[0].cyc <= cyc)) begin
                    failures++;
                    $display("FAIL idle_cycle cyc=%0d: actual busy=0 ab=%b%b done=%b pending=%0d required quiet with no burst due",
                             cyc, bus.a, bus.b, bus.done, q.size());
                end
            end
`ifdef SEQGEN_MONITOR_EN
            checks++;
            if (bus.mon_y != ((ms == 1) || (ms == 2))) begin
                failures++;
                $display("FAIL mon_y cyc=%0d: actual %b required %b", cyc, bus.mon_y, (ms == 1) || (ms == 2));
            end
            ms = reset ? mon_next(ms, bus.a, bus.b) : 0;
`endif
        end
    end

    initial begin
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.hold_len = '0;
        cyc          = 0;
        checks       = 0;
        failures     = 0;
        rem          = 0;
        ms           = 0;
        mon_en       = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.a, bus.b, bus.busy, bus.done} != 4'b0000) begin
            failures++;
            $display("FAIL reset_state: actual a,b,busy,done=%b%b%b%b required 0000",
                     bus.a, bus.b, bus.busy, bus.done);
        end
        mon_en = 1'b1;

        // Release reset with start already high. The first edge must accept it.
        drive(1'b1, 4'd3, 1'b1);
        repeat (8) drive(1'b0, 4'($urandom_range(0, 15)), 1'b0);

        // Shortest burst.
        drive(1'b1, 4'd0, 1'b0);
        repeat (5) drive(1'b0, 4'd0, 1'b0);

        // Start held high. Bursts are separated by one idle cycle.
        repeat (14) drive(1'b1, 4'd1, 1'b0);
        repeat (3) drive(1'b0, 4'd0, 1'b0);

        // Maximum hold length. hold_len changes after acceptance.
        drive(1'b1, 4'd15, 1'b0);
        repeat (22) drive(1'b0, 4'd2, 1'b0);

        // Reset during HOLD of a hold_len=5 burst.
        drive(1'b1, 4'd5, 1'b0);
        repeat (3) drive(1'b0, 4'd0, 1'b0);
        do_reset();
        repeat (2) drive(1'b0, 4'd0, 1'b0);
        drive(1'b1, 4'd4, 1'b1);
        repeat (8) drive(1'b0, 4'd0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  4'($urandom_range(0, 15)), 1'b0);
        end
        repeat (25) drive(1'b0, 4'd0, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: actual pending=%0d required 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_generator.md
SEQ_GENERATOR -- requirements
Module: seq_generator

Interface
REQ-001 Parameter HOLD_W, default 4, width of the hold-length input and the hold counter.
REQ-002 Parameter XOR_PAT, default 2'b10, {a,b} value emitted in the first step; legal values 2'b10 or 2'b01.
REQ-003 Port clk  input  1  sole clock, rising-edge active.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  request to emit one pattern burst, sampled on the rising clk edge.
REQ-006 Port hold_len  input  HOLD_W  number of extra {a,b}=11 cycles after step 2, latched at the accepted start.
REQ-007 Port a  output  1  generated stream bit a, registered.
REQ-008 Port b  output  1  generated stream bit b, registered.
REQ-009 Port busy  output  1  high while a burst is being emitted, registered.
REQ-010 Port done  output  1  one-cycle pulse marking the final burst cycle, registered.
REQ-011 Port mon_y  output  1  detector-model output; present only when SEQGEN_MONITOR_EN is defined.

Function
REQ-012 The FSM SHALL have states IDLE, STEP1, STEP2, HOLD and TERM.
REQ-013 {a,b} SHALL be 00 in IDLE, XOR_PAT in STEP1, 11 in STEP2, 11 in HOLD and 00 in TERM.
REQ-014 IDLE with start=1 at a rising edge SHALL go to STEP1 and latch hold_len into the hold counter.
REQ-015 STEP1 SHALL always go to STEP2 after exactly one cycle.
REQ-016 STEP2 SHALL go to HOLD when the latched length is nonzero, else to TERM.
REQ-017 HOLD SHALL decrement the counter each cycle and go to TERM after exactly the latched number of cycles.
REQ-018 TERM SHALL go to IDLE after one cycle.
REQ-019 Latency: {a,b} SHALL equal XOR_PAT in the cycle immediately after the edge that samples start.
REQ-020 busy SHALL be 1 in STEP1, STEP2, HOLD and TERM, and 0 in IDLE.
REQ-021 done SHALL be 1 only in the TERM cycle.
REQ-022 Burst length SHALL be hold_len+3 cycles; hold_len=0 gives the 3-cycle sequence XOR_PAT,11,00.
REQ-023 start while busy=1, including in the TERM cycle, SHALL be ignored and not queued.
REQ-024 Changes on hold_len after the accepted start SHALL NOT affect the current burst.
REQ-025 hold_len at its maximum value (2^HOLD_W-1) SHALL be honoured with no wrap of the counter.
REQ-026 An illegal XOR_PAT (00 or 11) SHALL cause an elaboration-time error.

Reset
REQ-027 reset=0 SHALL, asynchronously, force state IDLE, a=0, b=0, busy=0, done=0, hold counter=0 and, if present, the monitor model state to S0.
REQ-028 Reset asserted mid-burst SHALL abort the burst with no done pulse.
REQ-029 After reset deassertion, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-030 With SEQGEN_MONITOR_EN defined, the block SHALL include a detector model clocked on clk and fed by the registered a,b.
REQ-031 Model state encoding: S0, S1, S2, S3.
REQ-032 Model transitions:
- S0 to S1 on a^b, else S0.
- S1 to S2 on a&b, else S0.
- S2 to S3 on a|b, else S0.
- S3 to S3 on a|b, else S0.
REQ-033 With SEQGEN_MONITOR_EN defined, mon_y SHALL be 1 when the model state is S1 or S2, and 0 otherwise.
REQ-034 Without SEQGEN_MONITOR_EN, the mon_y port and the detector model SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-035 Scenario: reset released, start=1 with hold_len=3 -> {a,b} = 10,11,11,11,11,00 over 6 cycles; busy high for those 6 cycles; done high only in the 6th; then 00 and idle.
REQ-036 Scenario: hold_len=0 -> {a,b} = 10,11,00; busy high for 3 cycles; done in the 3rd.
REQ-037 Scenario: start held high continuously, hold_len=1 -> bursts of 4 cycles separated by exactly one IDLE cycle; no start is accepted during TERM.
REQ-038 Scenario: reset driven low during the HOLD of a hold_len=5 burst -> a, b, busy and done are 0 immediately, without a clock edge; no done pulse follows.
REQ-039 Scenario: hold_len=15 with HOLD_W=4, changed to 2 after the accepted start -> burst lasts 18 cycles.
REQ-040 Scenario (SEQGEN_MONITOR_EN defined): hold_len=2 -> mon_y reads 0,1,1,0,0,0,0 starting at the cycle STEP1 appears; the model returns to S0 one cycle after TERM.
